ib_v2c_wb_ctrl: RTL and testbench
=================================

# ib_v2c_wb_ctrl

Write-back controller for the outgoing variable-to-check (v2c) messages of one degree-3 IB variable node unit. It samples the VNU's three v2c outputs (or the channel LLR during the first iteration), delays them through a pipeline matched to the c2v pipeline depth, and writes them into the v2c message RAM at a layer-indexed address. It sequences layers and iterations for one codeword and reports completion, forming the write end of the message path whose read end feeds the VNU routing logic.

## Interface
- QUAN_SIZE, 4, message width in bits
- PIPELINE_DEPTH, 3, pipeline stages; write latency is PIPELINE_DEPTH-1 register stages; legal values are 2 and above
- LAYER_NUM, 4, layers per iteration
- ADDR_WIDTH, 2, RAM address width; must satisfy 2^ADDR_WIDTH >= LAYER_NUM
- MAX_ITER, 10, iterations per codeword; legal values are 1 and above
- ITER_WIDTH, 4, iteration counter width; must hold MAX_ITER-1
- read_clk  in  1  sole clock, rising edge
- rstn  in  1  asynchronous active-low reset
- iter_start  in  1  one-cycle pulse that starts decoding of a new codeword
- vnu_valid  in  1  M0/M1/M2/ch_llr hold the VNU result for the current layer
- M0, M1, M2  in  QUAN_SIZE each  VNU v2c messages
- ch_llr  in  QUAN_SIZE  channel LLR of this variable node
- v2c_we  out  1  RAM write enable
- v2c_addr  out  ADDR_WIDTH  RAM write address (layer index)
- v2c_wdata  out  3*QUAN_SIZE  packed word {M2_src, M1_src, M0_src}
- v2c_src  out  1  high while the first iteration is being sampled (bypass active)
- iter_cnt  out  ITER_WIDTH  current iteration index
- busy  out  1  high in FIRST, NORMAL and DRAIN states
- done  out  1  one-cycle pulse, coincident with the final write

## Operation
- States:
  - IDLE: initial state.
  - FIRST: iteration 0; the channel LLR is bypassed.
  - NORMAL: iterations 1 to MAX_ITER-1.
  - DRAIN: the last sample has been taken and the pipeline is emptying.
- Transitions:
  - IDLE with iter_start goes to FIRST. On entry, layer_cnt and iter_cnt are set to 0.
  - iter_start is ignored in every other state.
- Sampling happens in FIRST or NORMAL on each cycle where vnu_valid=1. Each sample captures:
  - data: ch_llr replicated into all three fields when in FIRST; {M2,M1,M0} when in NORMAL.
  - addr = layer_cnt.
  - a last flag, set when layer_cnt=LAYER_NUM-1 and iter_cnt=MAX_ITER-1.
- Counter update on each sample:
  - If layer_cnt=LAYER_NUM-1, layer_cnt wraps to 0 and iter_cnt increments. Otherwise layer_cnt increments.
  - A sample in FIRST with layer_cnt=LAYER_NUM-1 moves the state to NORMAL.
  - A sample with the last flag set moves the state to DRAIN. This takes priority, so MAX_ITER=1 goes FIRST→DRAIN.
  - On the last sample, iter_cnt holds at MAX_ITER-1 and does not increment.
- vnu_valid in IDLE or DRAIN is ignored: no write, no counter change.
- DRAIN→IDLE happens in the cycle the last-flagged entry reaches the output; done=1 in that same cycle.
- v2c_src = 1 exactly when state=FIRST. It is combinational from state.
- Pipeline:
  - PIPELINE_DEPTH-1 stages, each holding {valid, last, addr, data}.
  - Stages advance every cycle, with no stall and no backpressure.
  - The stage valid bits are reset to 0. Data registers need no reset.

## Timing
- Reset values:
  - v2c_we=0, v2c_addr=0, v2c_wdata=0, v2c_src=0, iter_cnt=0, busy=0, done=0.
  - state=IDLE, layer_cnt=0, all pipeline valid bits 0.
- Reset takes effect asynchronously. Asserting rstn mid-codeword discards all in-flight entries; no write appears after reset is released.
- Latency: a sample at edge t produces v2c_we=1 with its addr and data during the cycle after edge t+PIPELINE_DEPTH-2. With the default depth this is 2 cycles after vnu_valid.
- Outputs v2c_we, v2c_addr, v2c_wdata and done are registered (driven by the last pipeline stage). v2c_src and busy decode the state register.
- Throughput is one sample per cycle, sustained. Back-to-back vnu_valid across an iteration boundary loses nothing.
- iter_start on the same edge as the final write (state DRAIN) is ignored. iter_start one cycle after done is accepted.
- busy falls in the cycle after done.

## Test plan
- Reset, then default parameters, iter_start, and vnu_valid held high for 4 cycles with ch_llr=4'h5 and M0/M1/M2=1/2/3 → writes at addr 0,1,2,3 with wdata=12'h555, 2 cycles after each sample; v2c_src=1 for those 4 samples, then 0; iter_cnt=1.
- Continue with 36 further valid samples, M0/M1/M2=4'h1/4'h2/4'h3 → wdata=12'h321, addr cycles 0..3, iter_cnt reaches 9; done pulses together with the 40th write; busy=0 on the next cycle.
- vnu_valid toggled 1,0,1,0 in NORMAL → exactly 2 writes, addresses consecutive, spaced 2 cycles apart.
- MAX_ITER=1, LAYER_NUM=4 → 4 bypass writes; done on the 4th write; the state never visits NORMAL.
- rstn low for 1 cycle while 2 entries are in flight → no write after reset; state IDLE; iter_start then restarts at addr 0, iter_cnt 0.
- iter_start pulsed during NORMAL and again during DRAIN → ignored; counters and write sequence unchanged.

Source files
------------

// File: rtl/ib_v2c_wb_ctrl.sv
// V2C write-back controller for one degree-3 IB variable node: samples VNU outputs
// (channel LLR on iteration 0), delays them to match the c2v path, writes by layer.
//
// state  | meaning
// IDLE   | waiting for iter_start
// FIRST  | iteration 0, channel LLR bypassed into all three fields
// NORMAL | iterations 1..MAX_ITER-1, VNU messages written
// DRAIN  | final sample taken, pipeline emptying
module ib_v2c_wb_ctrl #(
   parameter int QUAN_SIZE      = 4,
   parameter int PIPELINE_DEPTH = 3,
   parameter int LAYER_NUM      = 4,
   parameter int ADDR_WIDTH     = 2,
   parameter int MAX_ITER       = 10,
   parameter int ITER_WIDTH     = 4
) (
   input  logic                   read_clk,
   input  logic                   rstn,
   input  logic                   iter_start,
   input  logic                   vnu_valid,
   input  logic [QUAN_SIZE-1:0]   M0,
   input  logic [QUAN_SIZE-1:0]   M1,
   input  logic [QUAN_SIZE-1:0]   M2,
   input  logic [QUAN_SIZE-1:0]   ch_llr,
   output logic                   v2c_we,
   output logic [ADDR_WIDTH-1:0]  v2c_addr,
   output logic [3*QUAN_SIZE-1:0] v2c_wdata,
   output logic                   v2c_src,
   output logic [ITER_WIDTH-1:0]  iter_cnt,
   output logic                   busy,
   output logic                   done
);

   localparam int STAGES = PIPELINE_DEPTH - 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_LAYER = ADDR_WIDTH'(LAYER_NUM - 1);
   localparam logic [ITER_WIDTH-1:0] LAST_ITER  = ITER_WIDTH'(MAX_ITER - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FIRST  = 2'd1,
      S_NORMAL = 2'd2,
      S_DRAIN  = 2'd3
   } state_t;

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_layer_cnt;
   logic [ITER_WIDTH-1:0]   r_iter_cnt;

   logic [STAGES-1:0]                    r_vld;
   logic [STAGES-1:0]                    r_last;
   logic [STAGES-1:0][ADDR_WIDTH-1:0]    r_addr;
   logic [STAGES-1:0][3*QUAN_SIZE-1:0]   r_data;

   logic                   w_sample;
   logic                   w_layer_end;
   logic                   w_last;
   logic                   w_final_out;
   logic [3*QUAN_SIZE-1:0] w_data;

   assign w_sample    = vnu_valid && (r_state == S_FIRST || r_state == S_NORMAL);
   assign w_layer_end = (r_layer_cnt == LAST_LAYER);
   assign w_last      = w_layer_end && (r_iter_cnt == LAST_ITER);
   assign w_data      = (r_state == S_FIRST) ? {ch_llr, ch_llr, ch_llr} : {M2, M1, M0};
   assign w_final_out = r_vld[STAGES-1] && r_last[STAGES-1];

   always_ff @(posedge read_clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_layer_cnt <= '0;
         r_iter_cnt  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (iter_start) begin
                  r_state     <= S_FIRST;
                  r_layer_cnt <= '0;
                  r_iter_cnt  <= '0;
               end
            end
            S_FIRST, S_NORMAL: begin
               if (w_sample) begin
                  r_layer_cnt <= w_layer_end ? '0 : r_layer_cnt + 1'b1;
                  // the final sample leaves iter_cnt parked at MAX_ITER-1
                  if (w_layer_end && !w_last)
                     r_iter_cnt <= r_iter_cnt + 1'b1;
                  if (w_last)
                     r_state <= S_DRAIN;
                  else if (r_state == S_FIRST && w_layer_end)
                     r_state <= S_NORMAL;
               end
            end
            S_DRAIN: begin
               if (w_final_out)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge read_clk or negedge rstn) begin
      if (!rstn) begin
         r_vld  <= '0;
         r_last <= '0;
         r_addr <= '0;
         r_data <= '0;
      end else begin
         r_vld[0]  <= w_sample;
         r_last[0] <= w_sample && w_last;
         r_addr[0] <= r_layer_cnt;
         r_data[0] <= w_data;
         for (int i = 1; i < STAGES; i++) begin
            r_vld[i]  <= r_vld[i-1];
            r_last[i] <= r_last[i-1];
            r_addr[i] <= r_addr[i-1];
            r_data[i] <= r_data[i-1];
         end
      end
   end

   assign v2c_we    = r_vld[STAGES-1];
   assign v2c_addr  = r_addr[STAGES-1];
   assign v2c_wdata = r_data[STAGES-1];
   assign done      = w_final_out;
   assign v2c_src   = (r_state == S_FIRST);
   assign busy      = (r_state != S_IDLE);
   assign iter_cnt  = r_iter_cnt;

endmodule

// File: tb/tb_ib_v2c_wb_ctrl.sv
// Bench for ib_v2c_wb_ctrl: table of opening cycles, write scoreboard for the full
// codeword, plus hand-written reset, restart and MAX_ITER=1 sequences.
module tb_ib_v2c_wb_ctrl;
   localparam int L    = 4;
   localparam int MAXA = 10;

   logic read_clk = 1'b0;
   always #5 read_clk = ~read_clk;

   logic       rstn, iter_start, vnu_valid, ib_start, ib_valid;
   logic [3:0] M0, M1, M2, ch_llr;

   logic        a_we, a_src, a_busy, a_done;
   logic [1:0]  a_addr;
   logic [11:0] a_wdata;
   logic [3:0]  a_iter;
   logic        b_we, b_src, b_busy, b_done;
   logic [1:0]  b_addr;
   logic [11:0] b_wdata;
   logic [3:0]  b_iter;

   ib_v2c_wb_ctrl #(.QUAN_SIZE(4), .PIPELINE_DEPTH(3), .LAYER_NUM(L), .ADDR_WIDTH(2),
                    .MAX_ITER(MAXA), .ITER_WIDTH(4)) dut_a (
      .read_clk(read_clk), .rstn(rstn), .iter_start(iter_start), .vnu_valid(vnu_valid),
      .M0(M0), .M1(M1), .M2(M2), .ch_llr(ch_llr),
      .v2c_we(a_we), .v2c_addr(a_addr), .v2c_wdata(a_wdata), .v2c_src(a_src),
      .iter_cnt(a_iter), .busy(a_busy), .done(a_done));

   ib_v2c_wb_ctrl #(.QUAN_SIZE(4), .PIPELINE_DEPTH(3), .LAYER_NUM(L), .ADDR_WIDTH(2),
                    .MAX_ITER(1), .ITER_WIDTH(4)) dut_b (
      .read_clk(read_clk), .rstn(rstn), .iter_start(ib_start), .vnu_valid(ib_valid),
      .M0(M0), .M1(M1), .M2(M2), .ch_llr(ch_llr),
      .v2c_we(b_we), .v2c_addr(b_addr), .v2c_wdata(b_wdata), .v2c_src(b_src),
      .iter_cnt(b_iter), .busy(b_busy), .done(b_done));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int         due;
      logic [1:0] addr;
      logic [11:0] data;
      logic       done;
   } wr_t;
   wr_t q[$];

   int cyc     = 0;
   int m_phase = 0;   // 0 idle, 1 sampling, 2 draining
   int m_k     = 0;   // samples taken in this codeword
   int m_iter  = 0;
   int m_end   = 0;

   task automatic step(input bit st, input bit vv);
      wr_t w;
      @(negedge read_clk);
      iter_start = st;
      vnu_valid  = vv;
      @(posedge read_clk);
      cyc++;
      if (m_phase == 2) begin
         if (cyc == m_end) m_phase = 0;
      end else if (m_phase == 0) begin
         if (st) begin
            m_phase = 1;
            m_k     = 0;
            m_iter  = 0;
         end
      end else if (vv) begin
         w.due  = cyc + 1;
         w.addr = 2'(m_k % L);
         w.data = (m_k < L) ? {ch_llr, ch_llr, ch_llr} : {M2, M1, M0};
         w.done = (m_k == L*MAXA - 1);
         q.push_back(w);
         if (m_k == L*MAXA - 1) begin
            m_phase = 2;
            m_end   = cyc + 2;
         end
         m_k++;
         m_iter = (m_k / L > MAXA - 1) ? MAXA - 1 : m_k / L;
      end
      #1;
      chk("busy", 32'(a_busy), 32'(m_phase != 0));
      chk("src", 32'(a_src), 32'(m_phase == 1 && m_k < L));
      chk("iter_cnt", 32'(a_iter), 32'(m_iter));
      if (q.size() > 0 && q[0].due == cyc) begin
         chk("we", 32'(a_we), 32'd1);
         chk("addr", 32'(a_addr), 32'(q[0].addr));
         chk("wdata", 32'(a_wdata), 32'(q[0].data));
         chk("done", 32'(a_done), 32'(q[0].done));
         void'(q.pop_front());
      end else begin
         chk("we_idle", 32'(a_we), 32'd0);
         chk("done_idle", 32'(a_done), 32'd0);
      end
   endtask

   task automatic reset_check(input string tag);
      chk({tag, "_we"},    32'(a_we),    32'd0);
      chk({tag, "_addr"},  32'(a_addr),  32'd0);
      chk({tag, "_wdata"}, 32'(a_wdata), 32'd0);
      chk({tag, "_src"},   32'(a_src),   32'd0);
      chk({tag, "_iter"},  32'(a_iter),  32'd0);
      chk({tag, "_busy"},  32'(a_busy),  32'd0);
      chk({tag, "_done"},  32'(a_done),  32'd0);
      chk({tag, "_b_busy"}, 32'(b_busy), 32'd0);
      chk({tag, "_b_we"},   32'(b_we),   32'd0);
   endtask

   typedef struct {
      logic        st;
      logic        vv;
      logic        we;
      logic [1:0]  addr;
      logic [11:0] wd;
      logic        src;
      logic        busy;
      logic [3:0]  iter;
   } vec_t;
   vec_t tbl[7];

   initial begin
      // first iteration from reset: ch_llr=5 bypassed, M ignored
      tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 12'h000, 1'b1, 1'b1, 4'd0};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 2'd0, 12'h000, 1'b1, 1'b1, 4'd0};
      tbl[2] = '{1'b0, 1'b1, 1'b1, 2'd0, 12'h555, 1'b1, 1'b1, 4'd0};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 2'd1, 12'h555, 1'b1, 1'b1, 4'd0};
      tbl[4] = '{1'b0, 1'b1, 1'b1, 2'd2, 12'h555, 1'b0, 1'b1, 4'd1};
      tbl[5] = '{1'b0, 1'b0, 1'b1, 2'd3, 12'h555, 1'b0, 1'b1, 4'd1};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 2'd0, 12'h000, 1'b0, 1'b1, 4'd1};

      rstn = 1'b0; iter_start = 1'b0; vnu_valid = 1'b0; ib_start = 1'b0; ib_valid = 1'b0;
      ch_llr = 4'h5; M0 = 4'h1; M1 = 4'h2; M2 = 4'h3;
      repeat (2) @(posedge read_clk);
      #1;
      reset_check("rst");
      @(negedge read_clk);
      rstn = 1'b1;

      for (int i = 0; i < 7; i++) begin
         step(tbl[i].st, tbl[i].vv);
         chk($sformatf("tbl%0d_we", i),   32'(a_we),   32'(tbl[i].we));
         chk($sformatf("tbl%0d_src", i),  32'(a_src),  32'(tbl[i].src));
         chk($sformatf("tbl%0d_busy", i), 32'(a_busy), 32'(tbl[i].busy));
         chk($sformatf("tbl%0d_iter", i), 32'(a_iter), 32'(tbl[i].iter));
         if (tbl[i].we) begin
            chk($sformatf("tbl%0d_addr", i),  32'(a_addr),  32'(tbl[i].addr));
            chk($sformatf("tbl%0d_wdata", i), 32'(a_wdata), 32'(tbl[i].wd));
         end
      end

      // sparse valid in NORMAL, then an iter_start that must be ignored
      step(0, 1); step(0, 0); step(0, 1); step(0, 0);
      step(1, 0);
      for (int i = 0; i < 34; i++) step(0, 1);
      chk("iter_at_drain", 32'(a_iter), 32'd9);
      // iter_start during DRAIN (twice) is ignored, one cycle after done it is accepted
      step(1, 0); step(1, 0); step(1, 0);
      chk("restart_src", 32'(a_src), 32'd1);

      ch_llr = 4'hA;
      step(0, 1); step(0, 1);
      @(negedge read_clk);
      rstn = 1'b0;
      #1;
      reset_check("midrst");
      q.delete();
      m_phase = 0; m_k = 0; m_iter = 0;
      @(posedge read_clk);
      cyc++;
      @(negedge read_clk);
      rstn = 1'b1;
      step(0, 0); step(0, 0); step(0, 0);
      step(1, 0); step(0, 1); step(0, 1);
      step(0, 0); step(0, 0); step(0, 0);
      chk("sb_empty", 32'(q.size()), 32'd0);

      // MAX_ITER=1 instance: four bypass writes, done on the fourth, no NORMAL phase
      ch_llr = 4'h9;
      @(negedge read_clk); ib_start = 1'b1;
      @(posedge read_clk); #1;
      chk("b_start_src", 32'(b_src), 32'd1);
      chk("b_start_busy", 32'(b_busy), 32'd1);
      @(negedge read_clk); ib_start = 1'b0; ib_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge read_clk); #1;
         chk($sformatf("b_s%0d_src", i), 32'(b_src), 32'(i < 3));
         chk($sformatf("b_s%0d_we", i), 32'(b_we), 32'(i >= 1));
         chk($sformatf("b_s%0d_done", i), 32'(b_done), 32'd0);
         if (i >= 1) begin
            chk($sformatf("b_s%0d_addr", i), 32'(b_addr), 32'(i - 1));
            chk($sformatf("b_s%0d_wdata", i), 32'(b_wdata), 32'h999);
         end
      end
      @(posedge read_clk); #1;
      chk("b_last_we", 32'(b_we), 32'd1);
      chk("b_last_addr", 32'(b_addr), 32'd3);
      chk("b_last_wdata", 32'(b_wdata), 32'h999);
      chk("b_last_done", 32'(b_done), 32'd1);
      chk("b_last_busy", 32'(b_busy), 32'd1);
      chk("b_last_src", 32'(b_src), 32'd0);
      @(posedge read_clk); #1;
      chk("b_post_we", 32'(b_we), 32'd0);
      chk("b_post_busy", 32'(b_busy), 32'd0);
      @(negedge read_clk); ib_valid = 1'b0;
      @(posedge read_clk); #1;
      chk("b_post2_we", 32'(b_we), 32'd0);
      chk("b_post2_done", 32'(b_done), 32'd0);
      chk("b_iter", 32'(b_iter), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
